// File: rtl/nvram_ctrl.sv
// nvram_ctrl: single-outstanding valid/ready initiator for one NVR_TOP macro, including the POR power-up pulse
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        core request handshake; req_we_i, req_addr_i, req_wdata_i describe the access
//   rsp_valid_o/rsp_rdata_o/rsp_err_o  one-cycle response pulse, read data, RDY timeout flag
//   init_done_o/init_err_o         POR sequence finished / RDY never rose after POR (sticky)
//   nvr_a_o/nvr_din_o/nvr_ce_o/nvr_we_o/nvr_por_o/nvr_hs_o/nvr_hr_o  macro address, data and strobes
//   nvr_dout_i/nvr_rdy_i           macro read data and asynchronous ready
module nvram_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int SETUP_CYC   = 2,
  parameter int CE_CYC      = 1,
  parameter int HOLD_CYC    = 7,
  parameter int POR_CYC     = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              init_done_o,
  output logic              init_err_o,
  output logic [ADDR_W-1:0] nvr_a_o,
  output logic [DATA_W-1:0] nvr_din_o,
  output logic              nvr_ce_o,
  output logic              nvr_we_o,
  output logic              nvr_por_o,
  output logic              nvr_hs_o,
  output logic              nvr_hr_o,
  input  logic [DATA_W-1:0] nvr_dout_i,
  input  logic              nvr_rdy_i
);
  typedef enum logic [3:0] {POR_HI, POR_WAIT, IDLE, SETUP, STROBE, HOLD, ACK, DONE, RESP} state_e;
  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, tmo_q, tmo_d;
  logic [1:0]        sync_q;
  logic              rdy_s;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] din_q, din_d, rdata_q, rdata_d;
  logic              we_q, we_d, ce_q, ce_d, por_q, por_d, err_q, err_d, done_q, done_d, ierr_q, ierr_d;
  assign rdy_s       = sync_q[1];
  assign req_ready_o = (state_q == IDLE) && done_q;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign init_done_o = done_q;
  assign init_err_o  = ierr_q;
  assign nvr_a_o     = a_q;
  assign nvr_din_o   = din_q;
  assign nvr_ce_o    = ce_q;
  assign nvr_we_o    = we_q;
  assign nvr_por_o   = por_q;
  assign nvr_hs_o    = 1'b0;
  assign nvr_hr_o    = 1'b0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= POR_HI;
      cnt_q   <= '0;
      tmo_q   <= '0;
      sync_q  <= '0;
      a_q     <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      ce_q    <= 1'b0;
      por_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ierr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      sync_q  <= {sync_q[0], nvr_rdy_i};
      a_q     <= a_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      ce_q    <= ce_d;
      por_q   <= por_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ierr_q  <= ierr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    tmo_d   = tmo_q;
    a_d     = a_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    done_d  = done_q;
    ierr_d  = ierr_q;
    case (state_q)
      // por_q lags state by one edge, so POR_HI lasts one extra count to give POR_CYC high cycles
      POR_HI:   if (cnt_q == 8'(POR_CYC)) state_d = POR_WAIT;
      POR_WAIT: begin
        if (rdy_s || cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ierr_d  = !rdy_s;
        end
      end
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          state_d = SETUP;
          a_d     = req_addr_i;
          din_d   = req_wdata_i;
          we_d    = req_we_i;
          tmo_d   = '0;
        end
      end
      SETUP:  if (cnt_q == 8'(SETUP_CYC - 1)) state_d = STROBE;
      STROBE: if (cnt_q == 8'(CE_CYC - 1)) state_d = (we_q && HOLD_CYC > 0) ? HOLD : ACK;
      HOLD:   if (cnt_q == 8'(HOLD_CYC - 1)) state_d = ACK;
      ACK, DONE: begin
        tmo_d = tmo_q + 8'd1;
        // a completed handshake wins over a timeout landing on the same cycle
        if (state_q == ACK && !rdy_s) begin
          state_d = DONE;
        end else if (state_q == DONE && rdy_s) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : nvr_dout_i;
          err_d   = 1'b0;
        end else if (tmo_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = POR_HI;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (state_d == RESP) we_d = 1'b0;
    ce_d  = state_d == STROBE;
    por_d = state_d == POR_HI;
  end
endmodule
